// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Latency: D inputs reach the ALU after 1 edge and the *_m outputs after 2; pcsrc_e/pctarget_e are combinational in E.
// Backpressure: stall_e holds ID/EX and flush_e loads a bubble (flush wins); EX/MEM never stalls.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   stall_e, flush_e             hazard-unit controls for the ID/EX register
//   *_d                          Decode-stage operands and control
//   forwarda_e, forwardb_e       operand select: 00/11 reg, 01 result_w, 10 aluresult_m
//   result_w                     Writeback result for forwarding
//   rs1_e, rs2_e, rd_e,
//   resultsrc_e0                 E-stage fields for hazard detection
//   pcsrc_e, pctarget_e          fetch redirect and target
//   *_m                          EX/MEM register outputs
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] immext_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic [2:0]      alucontrol_d,
  input  logic            alusrc_d,
  input  logic            regwrite_d,
  input  logic            memwrite_d,
  input  logic [1:0]      resultsrc_d,
  input  logic            branch_d,
  input  logic            jump_d,
  input  logic [1:0]      forwarda_e,
  input  logic [1:0]      forwardb_e,
  input  logic [XLEN-1:0] result_w,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic            resultsrc_e0,
  output logic            pcsrc_e,
  output logic [XLEN-1:0] pctarget_e,
  output logic [XLEN-1:0] aluresult_m,
  output logic [XLEN-1:0] writedata_m,
  output logic [4:0]      rd_m,
  output logic            regwrite_m,
  output logic            memwrite_m,
  output logic [1:0]      resultsrc_m,
  output logic [XLEN-1:0] pcplus4_m
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      alucontrol;
    logic            alusrc;
    logic            regwrite;
    logic            memwrite;
    logic [1:0]      resultsrc;
    logic            branch;
    logic            jump;
  } idex_t;

  idex_t           d_in;
  idex_t           e;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] srcb;
  logic [XLEN-1:0] aluresult;
  logic [4:0]      shamt;
  logic            zero;

  always_comb begin
    d_in            = '0;
    d_in.rd1        = rd1_d;
    d_in.rd2        = rd2_d;
    d_in.imm        = immext_d;
    d_in.pc         = pc_d;
    d_in.rs1        = rs1_d;
    d_in.rs2        = rs2_d;
    d_in.rd         = rd_d;
    d_in.alucontrol = alucontrol_d;
    d_in.alusrc     = alusrc_d;
    d_in.regwrite   = regwrite_d;
    d_in.memwrite   = memwrite_d;
    d_in.resultsrc  = resultsrc_d;
    d_in.branch     = branch_d;
    d_in.jump       = jump_d;
  end

  // ID/EX: a bubble is an all-zero entry, so it never writes or redirects.
  always_ff @(posedge clk) begin
    if (!reset_n)     e <= '0;
    else if (flush_e) e <= '0;
    else if (!stall_e) e <= d_in;
  end

  // Forwarding muxes; the unused code 11 falls back to the register value.
  always_comb begin
    case (forwarda_e)
      2'b01:   srca = result_w;
      2'b10:   srca = aluresult_m;
      default: srca = e.rd1;
    endcase
    case (forwardb_e)
      2'b01:   wd = result_w;
      2'b10:   wd = aluresult_m;
      default: wd = e.rd2;
    endcase
  end

  assign srcb  = e.alusrc ? e.imm : wd;
  assign shamt = srcb[4:0];

  always_comb begin
    case (e.alucontrol)
      3'b010:  aluresult = srca + srcb;
      3'b110:  aluresult = srca - srcb;
      3'b000:  aluresult = srca & srcb;
      3'b001:  aluresult = srca | srcb;
      3'b111:  aluresult = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      3'b100:  aluresult = srca << shamt;
      3'b101:  aluresult = srca >> shamt;
      default: aluresult = '0;
    endcase
  end

  assign zero         = (aluresult == '0);
  assign pcsrc_e      = (e.branch & zero) | e.jump;
  assign pctarget_e   = e.pc + e.imm;
  assign rs1_e        = e.rs1;
  assign rs2_e        = e.rs2;
  assign rd_e         = e.rd;
  assign resultsrc_e0 = e.resultsrc[0];

  // EX/MEM loads every edge so a held E instruction re-enters M each cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      aluresult_m <= '0;
      writedata_m <= '0;
      rd_m        <= '0;
      regwrite_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      resultsrc_m <= '0;
      pcplus4_m   <= '0;
    end else begin
      aluresult_m <= aluresult;
      writedata_m <= wd;
      rd_m        <= e.rd;
      regwrite_m  <= e.regwrite;
      memwrite_m  <= e.memwrite;
      resultsrc_m <= e.resultsrc;
      pcplus4_m   <= e.pc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset_n, stall_e, flush_e;
  logic [31:0] rd1_d, rd2_d, immext_d, pc_d, result_w;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [2:0]  alucontrol_d;
  logic        alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
  logic [1:0]  resultsrc_d, forwarda_e, forwardb_e;
  logic [4:0]  rs1_e, rs2_e, rd_e, rd_m;
  logic        resultsrc_e0, pcsrc_e, regwrite_m, memwrite_m;
  logic [31:0] pctarget_e, aluresult_m, writedata_m, pcplus4_m;
  logic [1:0]  resultsrc_m;

  int nvec = 0;
  int nmis = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .immext_d(immext_d), .pc_d(pc_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
    .alusrc_d(alusrc_d), .regwrite_d(regwrite_d), .memwrite_d(memwrite_d),
    .resultsrc_d(resultsrc_d), .branch_d(branch_d), .jump_d(jump_d),
    .forwarda_e(forwarda_e), .forwardb_e(forwardb_e), .result_w(result_w),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .resultsrc_e0(resultsrc_e0),
    .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e), .aluresult_m(aluresult_m),
    .writedata_m(writedata_m), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .memwrite_m(memwrite_m), .resultsrc_m(resultsrc_m), .pcplus4_m(pcplus4_m)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] rd, input logic [2:0] alu, input logic asrc,
                       input logic rw, input logic mw, input logic [1:0] rs,
                       input logic br, input logic jp);
    rd1_d = a; rd2_d = b; immext_d = imm; pc_d = pc; rs1_d = s1; rs2_d = s2; rd_d = rd;
    alucontrol_d = alu; alusrc_d = asrc; regwrite_d = rw; memwrite_d = mw;
    resultsrc_d = rs; branch_d = br; jump_d = jp;
  endtask

  task automatic set_nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 0; stall_e = 0; flush_e = 0; forwarda_e = 0; forwardb_e = 0; result_w = 32'h5;
    set_d(32'h11, 32'h22, 32'h8, 32'h40, 5'd1, 5'd2, 5'd3, 3'b010, 1, 1, 1, 2'b01, 1, 1);
    tick(); tick();
    nvec++; if (aluresult_m !== 32'h0) begin nmis++; $display("FAIL reset aluresult_m got %h want 0", aluresult_m); end
    nvec++; if (writedata_m !== 32'h0) begin nmis++; $display("FAIL reset writedata_m got %h want 0", writedata_m); end
    nvec++; if (pcplus4_m !== 32'h0) begin nmis++; $display("FAIL reset pcplus4_m got %h want 0", pcplus4_m); end
    nvec++; if ({rd_m, regwrite_m, memwrite_m, resultsrc_m} !== 10'h0)
      begin nmis++; $display("FAIL reset m_ctrl got %h want 0", {rd_m, regwrite_m, memwrite_m, resultsrc_m}); end
    nvec++; if ({rd_e, rs1_e, rs2_e, resultsrc_e0} !== 16'h0)
      begin nmis++; $display("FAIL reset e_fields got %h want 0", {rd_e, rs1_e, rs2_e, resultsrc_e0}); end
    nvec++; if (pcsrc_e !== 1'b0) begin nmis++; $display("FAIL reset pcsrc_e got %b want 0", pcsrc_e); end
    reset_n = 1;
  endtask

  task automatic test_rtype();
    set_d(7, 9, 0, 0, 5'd1, 5'd2, 5'd5, 3'b110, 0, 1, 0, 2'b00, 0, 0);
    tick();
    nvec++; if (rd_e !== 5'd5) begin nmis++; $display("FAIL sub rd_e got %0d want 5", rd_e); end
    set_nop(); tick();
    nvec++; if (aluresult_m !== 32'hFFFFFFFE) begin nmis++; $display("FAIL sub aluresult_m got %h want fffffffe", aluresult_m); end
    nvec++; if (rd_m !== 5'd5 || regwrite_m !== 1'b1)
      begin nmis++; $display("FAIL sub rd_m/regwrite_m got %0d/%b want 5/1", rd_m, regwrite_m); end
    set_d(7, 9, 0, 0, 5'd1, 5'd2, 5'd6, 3'b111, 0, 1, 0, 2'b00, 0, 0);
    tick(); set_nop(); tick();
    nvec++; if (aluresult_m !== 32'h1) begin nmis++; $display("FAIL slt aluresult_m got %h want 1", aluresult_m); end
    // signed compare: -1 < 1
    set_d(32'hFFFFFFFF, 1, 0, 0, 0, 0, 5'd6, 3'b111, 0, 1, 0, 2'b00, 0, 0);
    tick(); set_nop(); tick();
    nvec++; if (aluresult_m !== 32'h1) begin nmis++; $display("FAIL slt_signed aluresult_m got %h want 1", aluresult_m); end
    set_d(32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 5'd6, 3'b001, 0, 1, 0, 2'b00, 0, 0);
    tick(); set_nop(); tick();
    nvec++; if (aluresult_m !== 32'hFFF0) begin nmis++; $display("FAIL or aluresult_m got %h want fff0", aluresult_m); end
    set_d(32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 5'd6, 3'b000, 0, 1, 0, 2'b00, 0, 0);
    tick(); set_nop(); tick();
    nvec++; if (aluresult_m !== 32'h00F0) begin nmis++; $display("FAIL and aluresult_m got %h want f0", aluresult_m); end
    set_d(32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 5'd6, 3'b011, 0, 1, 0, 2'b00, 0, 0);
    tick(); set_nop(); tick();
    nvec++; if (aluresult_m !== 32'h0) begin nmis++; $display("FAIL op011 aluresult_m got %h want 0", aluresult_m); end
  endtask

  task automatic test_forwarding();
    set_d(32'h10, 0, 0, 0, 0, 0, 5'd4, 3'b010, 0, 1, 0, 2'b00, 0, 0);
    tick();
    set_d(32'hDEAD, 32'h77, 0, 0, 5'd4, 5'd8, 5'd9, 3'b010, 0, 1, 0, 2'b00, 0, 0);
    tick();
    nvec++; if (aluresult_m !== 32'h10) begin nmis++; $display("FAIL fwd_setup aluresult_m got %h want 10", aluresult_m); end
    set_nop(); forwarda_e = 2'b10; forwardb_e = 2'b01; result_w = 32'h3;
    tick();
    nvec++; if (aluresult_m !== 32'h13) begin nmis++; $display("FAIL fwd_add aluresult_m got %h want 13", aluresult_m); end
    nvec++; if (writedata_m !== 32'h3) begin nmis++; $display("FAIL fwd_add writedata_m got %h want 3", writedata_m); end
    forwarda_e = 2'b00; forwardb_e = 2'b00;
    // Store: address from rd1 + imm, data forwarded from Writeback.
    set_d(32'h100, 32'hBAD, 32'h4, 0, 5'd1, 5'd2, 5'd0, 3'b010, 1, 0, 1, 2'b00, 0, 0);
    tick();
    set_nop(); forwardb_e = 2'b01; result_w = 32'h3;
    tick();
    nvec++; if (aluresult_m !== 32'h104) begin nmis++; $display("FAIL store aluresult_m got %h want 104", aluresult_m); end
    nvec++; if (writedata_m !== 32'h3 || memwrite_m !== 1'b1)
      begin nmis++; $display("FAIL store writedata_m/memwrite_m got %h/%b want 3/1", writedata_m, memwrite_m); end
    // Code 11 selects the register value.
    set_d(32'h20, 32'h5, 0, 0, 0, 0, 5'd1, 3'b010, 0, 1, 0, 2'b00, 0, 0);
    tick();
    set_nop(); forwarda_e = 2'b11; forwardb_e = 2'b11; result_w = 32'h1000;
    tick();
    nvec++; if (aluresult_m !== 32'h25) begin nmis++; $display("FAIL fwd11 aluresult_m got %h want 25", aluresult_m); end
    forwarda_e = 2'b00; forwardb_e = 2'b00;
  endtask

  task automatic test_branch();
    set_d(32'h55, 32'h55, 32'h20, 32'h100, 0, 0, 0, 3'b110, 0, 0, 0, 2'b00, 1, 0);
    tick();
    nvec++; if (pcsrc_e !== 1'b1) begin nmis++; $display("FAIL beq_taken pcsrc_e got %b want 1", pcsrc_e); end
    nvec++; if (pctarget_e !== 32'h120) begin nmis++; $display("FAIL beq pctarget_e got %h want 120", pctarget_e); end
    set_d(32'h55, 32'h56, 32'h20, 32'h100, 0, 0, 0, 3'b110, 0, 0, 0, 2'b00, 1, 0);
    tick();
    nvec++; if (pcsrc_e !== 1'b0) begin nmis++; $display("FAIL beq_not_taken pcsrc_e got %b want 0", pcsrc_e); end
    set_d(32'h1, 32'h2, 32'h20, 32'h100, 0, 0, 5'd1, 3'b110, 0, 1, 0, 2'b10, 0, 1);
    tick();
    nvec++; if (pcsrc_e !== 1'b1) begin nmis++; $display("FAIL jal pcsrc_e got %b want 1", pcsrc_e); end
    nvec++; if (resultsrc_e0 !== 1'b0) begin nmis++; $display("FAIL jal resultsrc_e0 got %b want 0", resultsrc_e0); end
    set_nop(); tick();
    nvec++; if (pcplus4_m !== 32'h104 || resultsrc_m !== 2'b10)
      begin nmis++; $display("FAIL jal pcplus4_m/resultsrc_m got %h/%b want 104/10", pcplus4_m, resultsrc_m); end
    // Wraparound of both PC adders.
    set_d(0, 0, 32'h8, 32'hFFFFFFFC, 0, 0, 0, 3'b000, 0, 0, 0, 2'b01, 0, 0);
    tick();
    nvec++; if (pctarget_e !== 32'h4 || resultsrc_e0 !== 1'b1)
      begin nmis++; $display("FAIL wrap pctarget_e/resultsrc_e0 got %h/%b want 4/1", pctarget_e, resultsrc_e0); end
    set_nop(); tick();
    nvec++; if (pcplus4_m !== 32'h0) begin nmis++; $display("FAIL wrap pcplus4_m got %h want 0", pcplus4_m); end
  endtask

  task automatic test_stall_flush();
    set_d(1, 2, 0, 32'h200, 5'd3, 5'd4, 5'd9, 3'b010, 0, 1, 0, 2'b00, 0, 0);
    tick();
    stall_e = 1;
    set_d(100, 0, 0, 32'h300, 5'd7, 5'd8, 5'd12, 3'b010, 0, 1, 1, 2'b00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (rd_e !== 5'd9 || rs1_e !== 5'd3 || rs2_e !== 5'd4)
        begin nmis++; $display("FAIL stall%0d e_fields got %0d/%0d/%0d want 9/3/4", i, rd_e, rs1_e, rs2_e); end
      nvec++; if (aluresult_m !== 32'h3 || rd_m !== 5'd9 || pcplus4_m !== 32'h204)
        begin nmis++; $display("FAIL stall%0d m got %h/%0d/%h want 3/9/204", i, aluresult_m, rd_m, pcplus4_m); end
    end
    stall_e = 0;
    tick();
    nvec++; if (rd_e !== 5'd12 || pcsrc_e !== 1'b1)
      begin nmis++; $display("FAIL unstall rd_e/pcsrc_e got %0d/%b want 12/1", rd_e, pcsrc_e); end
    flush_e = 1; stall_e = 1;
    tick();
    nvec++; if (rd_e !== 5'd0 || pcsrc_e !== 1'b0)
      begin nmis++; $display("FAIL flush rd_e/pcsrc_e got %0d/%b want 0/0", rd_e, pcsrc_e); end
    flush_e = 0; stall_e = 0;
    tick();
    nvec++; if (regwrite_m !== 1'b0 || memwrite_m !== 1'b0)
      begin nmis++; $display("FAIL bubble regwrite_m/memwrite_m got %b/%b want 0/0", regwrite_m, memwrite_m); end
    // Reset during a stall clears E; the stall is released afterwards.
    stall_e = 1; reset_n = 0;
    tick();
    nvec++; if (rd_e !== 5'd0 || rd_m !== 5'd0)
      begin nmis++; $display("FAIL reset_stall rd_e/rd_m got %0d/%0d want 0/0", rd_e, rd_m); end
    reset_n = 1; stall_e = 0;
    tick();
    nvec++; if (rd_e !== 5'd12) begin nmis++; $display("FAIL post_reset rd_e got %0d want 12", rd_e); end
    set_nop(); tick();
  endtask

  task automatic test_shifts();
    set_d(32'h80000001, 0, 32'h21, 0, 0, 0, 5'd2, 3'b100, 1, 1, 0, 2'b00, 0, 0);
    tick();
    set_d(32'h80000001, 0, 32'h21, 0, 0, 0, 5'd2, 3'b101, 1, 1, 0, 2'b00, 0, 0);
    tick();
    nvec++; if (aluresult_m !== 32'h00000002) begin nmis++; $display("FAIL sll aluresult_m got %h want 2", aluresult_m); end
    set_nop(); tick();
    nvec++; if (aluresult_m !== 32'h40000000) begin nmis++; $display("FAIL srl aluresult_m got %h want 40000000", aluresult_m); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_forwarding();
    test_branch();
    test_stall_flush();
    test_shifts();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
